mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported `memory` instance between two requesters: the instruction-fetch port (IF) and the load/store port (LS).
- Used once the design moves from a read-only imem to a unified instruction/data memory. It sits between `fetch`/execute-stage LS logic and `memory`.
- Sequences one transaction at a time: request/grant handshake, fixed read latency, then a single-cycle read response routed back to the owning requester.
- Priority is fixed to LS, with a starvation guard so IF always makes progress.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width.
- MEM_LATENCY, 1, cycles from read accept to valid mem_rdata_i. Legal range 1..7.
- STARVE_LIMIT, 4, consecutive LS grants allowed while IF is waiting before IF is forced in. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  IF read request
- if_addr_i  in  AWIDTH  IF read address
- if_gnt_o  out  1  IF request accepted this cycle
- if_rvalid_o  out  1  IF read data valid (1-cycle pulse)
- if_rdata_o  out  DWIDTH  IF read data
- ls_req_i  in  1  LS request
- ls_we_i  in  1  LS write (1) or read (0)
- ls_addr_i  in  AWIDTH  LS address
- ls_wdata_i  in  DWIDTH  LS write data
- ls_gnt_o  out  1  LS request accepted this cycle
- ls_rvalid_o  out  1  LS read data valid (1-cycle pulse)
- ls_rdata_o  out  DWIDTH  LS read data
- mem_addr_o  out  AWIDTH  address to memory
- mem_wdata_o  out  DWIDTH  write data to memory
- mem_read_en_o  out  1  memory read enable
- mem_write_en_o  out  1  memory write enable
- mem_rdata_i  in  DWIDTH  memory read data
- busy_o  out  1  arbiter not in IDLE

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, latency counter=0, starve counter=0, owner=IF. All outputs are 0. A transaction in flight is abandoned and no rvalid is produced.
- States:
  - IDLE: the only state in which a grant may occur.
  - WAIT: a read is outstanding and the latency counter is running.
  - RESP: response cycle.
- IDLE arbitration (combinational, same cycle as req):
  - LS wins if ls_req_i=1 and NOT (if_req_i=1 and starve==STARVE_LIMIT).
  - Otherwise IF wins if if_req_i=1.
  - At most one gnt is high in any cycle.
- On grant, in the grant cycle:
  - mem_addr_o = winner's address.
  - For an LS write: mem_write_en_o=1, mem_wdata_o=ls_wdata_i.
  - For a read: mem_read_en_o=1.
- LS write:
  - Completes in the grant cycle. No rvalid is produced.
  - State stays IDLE, so back-to-back writes are possible every cycle.
- Read accepted in cycle T:
  - Latch owner and address; go to WAIT with counter=MEM_LATENCY-1. If MEM_LATENCY==1, go directly to RESP.
  - mem_addr_o and mem_read_en_o are held stable from T through the RESP cycle.
  - WAIT decrements the counter and goes to RESP when it reaches 0.
  - RESP occurs in cycle T+MEM_LATENCY. In RESP: owner's rvalid=1 and owner's rdata=mem_rdata_i. The non-owner's rdata is 0. Next state is IDLE.
  - Earliest next grant is T+MEM_LATENCY+1.
- Requester rules:
  - A requester holds req and its address/data stable until it sees gnt.
  - Dropping req before gnt is legal and the request is simply withdrawn.
  - gnt is never asserted in WAIT or RESP, regardless of req.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each LS grant while if_req_i=1.
  - Clears to 0 on an IF grant, and on any IDLE cycle with if_req_i=0.
  - It is held during WAIT and RESP.
- busy_o=1 in WAIT and RESP.
- Simultaneous events:
  - Both requesting with starve below the limit: LS granted.
  - Both requesting with starve==limit: IF granted, then starve clears.
- No address decoding or alignment checks are done here; `memory` handles base offset and alignment.

Decomposition:
- Shared package `arb_pkg`:
  - arb_state_t enum {ARB_IDLE, ARB_WAIT, ARB_RESP}
  - arb_owner_t enum {OWN_IF, OWN_LS}
  - Widths of the latency counter and the starve counter, derived via $clog2.
- One natural sub-module: `arb_pick`, the combinational priority and starvation-guard picker.
  - Inputs: if_req, ls_req, starve_at_limit, idle.
  - Outputs: if_gnt, ls_gnt.
  - Reused later when a third requester (debug port) is added.

Test Plan:
- Reset mid-read (MEM_LATENCY=3):
  - Stimulus: IF read of 0x01000000 granted, then rst asserted 1 cycle later for 2 cycles.
  - Required: no if_rvalid_o; all outputs 0 during reset; IDLE after release.
- Single IF read (MEM_LATENCY=1):
  - Stimulus: if_req with addr 0x01000000, memory returns 0x00500093.
  - Required: if_gnt_o in cycle T; if_rvalid_o=1 with if_rdata_o=0x00500093 in T+1; next grant possible in T+2.
- Contention:
  - Stimulus: if_req and ls_req (read 0x01000100) both high in the same cycle, starve=0.
  - Required: ls_gnt_o=1 and if_gnt_o=0; IF granted in the first IDLE cycle after the LS response.
- Starvation guard (STARVE_LIMIT=4, LS writes):
  - Stimulus: ls_req writes asserted every cycle and if_req held high.
  - Required: exactly 4 LS grants, then IF granted on the 5th arbitration; starve returns to 0.
- Back-to-back writes:
  - Stimulus: 3 LS writes to 0x01000000, 0x01000004, 0x01000008 with data 0xA, 0xB, 0xC.
  - Required: 3 consecutive cycles with mem_write_en_o=1; busy_o stays 0; no rvalid.
- Latency hold (MEM_LATENCY=3):
  - Stimulus: LS read of 0x01000010; if_req asserted during WAIT.
  - Required: mem_addr_o stable for 4 cycles; ls_rvalid_o at T+3; no if_gnt_o before T+4.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and counter widths for the memory port arbiter
//
// Contents:
//   arb_state_t : IDLE (may grant), WAIT (read latency running), RESP (response cycle)
//   arb_owner_t : requester that owns the outstanding read
//   LAT_W       : latency counter width, sized for the largest legal MEM_LATENCY
//   STARVE_W    : starve counter width, sized for the largest legal STARVE_LIMIT
package arb_pkg;

  localparam int MAX_LATENCY = 7;
  localparam int MAX_STARVE  = 15;

  localparam int LAT_W    = $clog2(MAX_LATENCY + 1);
  localparam int STARVE_W = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational fixed-priority picker with IF starvation guard
//
// Ports:
//   if_req          in  IF requester wants the memory
//   ls_req          in  LS requester wants the memory
//   starve_at_limit in  LS has been granted STARVE_LIMIT times in a row over a waiting IF
//   idle            in  arbiter is able to grant this cycle
//   if_gnt          out IF granted
//   ls_gnt          out LS granted
module arb_pick (
  input  logic if_req,
  input  logic ls_req,
  input  logic starve_at_limit,
  input  logic idle,
  output logic if_gnt,
  output logic ls_gnt
);

  // LS normally wins; once IF has waited through the allowed number of LS
  // grants it is forced in. IF only wins when LS is not granted, so the two
  // grants are mutually exclusive.
  assign ls_gnt = idle & ls_req & ~(if_req & starve_at_limit);
  assign if_gnt = idle & if_req & ~ls_gnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between IF and LS requesters
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req_i/if_addr_i            IF read request and address
//   if_gnt_o                      IF request accepted this cycle
//   if_rvalid_o/if_rdata_o        IF read response (1-cycle pulse)
//   ls_req_i/ls_we_i              LS request, write (1) or read (0)
//   ls_addr_i/ls_wdata_i          LS address and write data
//   ls_gnt_o                      LS request accepted this cycle
//   ls_rvalid_o/ls_rdata_o        LS read response (1-cycle pulse)
//   mem_addr_o/mem_wdata_o        memory address and write data
//   mem_read_en_o/mem_write_en_o  memory strobes
//   mem_rdata_i                   memory read data, valid MEM_LATENCY cycles after accept
//   busy_o                        arbiter is in WAIT or RESP
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [AWIDTH-1:0] ls_addr_i,
  input  logic [DWIDTH-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DWIDTH-1:0] ls_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              busy_o
);

  arb_state_t           state;
  arb_owner_t           owner;
  logic [LAT_W-1:0]     lat_cnt;
  logic [STARVE_W-1:0]  starve;
  logic [AWIDTH-1:0]    addr_q;

  logic idle;
  logic starve_at_limit;
  logic if_gnt;
  logic ls_gnt;
  logic rd_grant;

  // Gate with rst so no grant or strobe leaks out while reset is held.
  assign idle            = (state == ARB_IDLE) && !rst;
  assign starve_at_limit = (starve == STARVE_W'(STARVE_LIMIT));

  arb_pick u_pick (
    .if_req          (if_req_i),
    .ls_req          (ls_req_i),
    .starve_at_limit (starve_at_limit),
    .idle            (idle),
    .if_gnt          (if_gnt),
    .ls_gnt          (ls_gnt)
  );

  // LS writes finish in the grant cycle; only reads need the WAIT/RESP sequence.
  assign rd_grant = if_gnt | (ls_gnt & ~ls_we_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      owner   <= OWN_IF;
      lat_cnt <= '0;
      starve  <= '0;
      addr_q  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (if_gnt || !if_req_i) begin
            starve <= '0;
          end else if (ls_gnt && !starve_at_limit) begin
            starve <= starve + 1'b1;
          end
          if (rd_grant) begin
            owner  <= ls_gnt ? OWN_LS : OWN_IF;
            addr_q <= ls_gnt ? ls_addr_i : if_addr_i;
            if (MEM_LATENCY == 1) begin
              state <= ARB_RESP;
            end else begin
              state   <= ARB_WAIT;
              lat_cnt <= LAT_W'(MEM_LATENCY - 1);
            end
          end
        end
        ARB_WAIT: begin
          // Leaving on count 1 lands RESP exactly MEM_LATENCY cycles after accept.
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) begin
            state <= ARB_RESP;
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    if_rvalid_o    = 1'b0;
    if_rdata_o     = '0;
    ls_rvalid_o    = 1'b0;
    ls_rdata_o     = '0;
    if ((state == ARB_WAIT || state == ARB_RESP) && !rst) begin
      // Address and read strobe stay put for the whole outstanding read.
      mem_addr_o    = addr_q;
      mem_read_en_o = 1'b1;
      if (state == ARB_RESP) begin
        if (owner == OWN_LS) begin
          ls_rvalid_o = 1'b1;
          ls_rdata_o  = mem_rdata_i;
        end else begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = mem_rdata_i;
        end
      end
    end else if (ls_gnt) begin
      mem_addr_o = ls_addr_i;
      if (ls_we_i) begin
        mem_write_en_o = 1'b1;
        mem_wdata_o    = ls_wdata_i;
      end else begin
        mem_read_en_o = 1'b1;
      end
    end else if (if_gnt) begin
      mem_addr_o    = if_addr_i;
      mem_read_en_o = 1'b1;
    end
  end

  assign if_gnt_o = if_gnt;
  assign ls_gnt_o = ls_gnt;
  assign busy_o   = (state != ARB_IDLE);

endmodule
